ddr3_cmd_sched: RTL and testbench

- DDR3 command scheduler between the CPU-side request interface and the memory-side command signals of the memory controller.
- Accepts one read/write request at a time and tracks the open row per bank.
- Issues ACT/RD/WR/PRE as each request needs, enforcing tRCD/tRP/tCCD.
- Inserts periodic all-bank refresh (PREA + REF) on a tREFI timer.

---
 rtl/ddr3_cmd_sched_if.sv | 27 ++
 rtl/ddr3_cmd_sched.sv | 205 ++++++++++++++++++++
 tb/tb_ddr3_cmd_sched.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_cmd_sched_if.sv
// CPU request / DDR3 command bus bundle for the command scheduler.
// master = request source and command sink, slave = scheduler.
interface ddr3_cmd_sched_if #(
  parameter int unsigned ROW_W = 15,
  parameter int unsigned COL_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_bank;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_bank;
  logic [ROW_W-1:0] cmd_addr;

  modport master (
    output req_valid, req_we, req_bank, req_row, req_col,
    input  req_ready, cmd_valid, cmd_op, cmd_bank, cmd_addr
  );

  modport slave (
    input  req_valid, req_we, req_bank, req_row, req_col,
    output req_ready, cmd_valid, cmd_op, cmd_bank, cmd_addr
  );
endinterface

// File: rtl/ddr3_cmd_sched.sv
// DDR3 command scheduler: one request at a time, per-bank open-row tracking,
// ACT/RD/WR/PRE timing (tRCD/tRP/tCCD) and periodic PREA+REF refresh.
module ddr3_cmd_sched #(
  parameter int unsigned ROW_W  = 15,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned T_RCD  = 3,
  parameter int unsigned T_RP   = 3,
  parameter int unsigned T_RFC  = 20,
  parameter int unsigned T_REFI = 200,
  parameter int unsigned T_CCD  = 4
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              init_done,
  ddr3_cmd_sched_if.slave   bus,
  output logic              ref_pending,
  output logic              busy
);

  localparam int unsigned T_MAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned T_MAX  = (T_RFC > T_MAX0) ? T_RFC : T_MAX0;
  localparam int unsigned WAIT_W = $clog2(T_MAX + 1);
  localparam int unsigned CCD_W  = $clog2(T_CCD + 1);
  localparam int unsigned REFI_W = $clog2(T_REFI + 1);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_PRE  = 3'd4;
  localparam logic [2:0] OP_PREA = 3'd5;
  localparam logic [2:0] OP_REF  = 3'd6;

  // A10 high selects all banks for a precharge.
  localparam logic [ROW_W-1:0] PREA_ADDR = ROW_W'(1024);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RCD_WAIT, S_RW, S_PRE, S_RP_WAIT,
    S_PREA, S_RP_ALL_WAIT, S_REF, S_RFC_WAIT
  } state_t;

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait;
  logic [CCD_W-1:0]   r_ccd;
  logic [REFI_W-1:0]  r_refi;
  logic [7:0]         r_open;
  logic [ROW_W-1:0]   r_row [8];
  logic               r_we;
  logic [2:0]         r_bank;
  logic [ROW_W-1:0]   r_req_row;
  logic [COL_W-1:0]   r_req_col;

  logic               w_accept;
  logic               w_hit;
  logic               w_any_open;
  logic               w_ref_start;
  logic               w_rw_issue;
  logic               w_ref_issue;
  logic               w_expire;
  logic               w_ref_pend_nxt;
  logic               w_idle_nxt;
  logic [CCD_W-1:0]   w_ccd_nxt;

  // Next-cycle view of the FSM, used to register req_ready/busy one cycle ahead.
  always_comb begin
    w_accept       = (r_state == S_IDLE) && bus.req_valid && bus.req_ready;
    w_hit          = r_open[bus.req_bank] && (r_row[bus.req_bank] == bus.req_row);
    w_any_open     = |r_open;
    w_ref_start    = (r_state == S_IDLE) && !w_accept && ref_pending && init_done;
    w_rw_issue     = (w_accept && w_hit) ||
                     (((r_state == S_ACT) || (r_state == S_RCD_WAIT)) && (r_wait == '0));
    w_ref_issue    = (w_ref_start && !w_any_open) ||
                     (((r_state == S_PREA) || (r_state == S_RP_ALL_WAIT)) && (r_wait == '0));
    w_expire       = init_done && (r_refi == '0);
    w_ref_pend_nxt = w_expire || (ref_pending && !w_ref_issue);
    w_ccd_nxt      = w_rw_issue ? CCD_W'(T_CCD - 1) :
                     ((r_ccd != '0) ? r_ccd - CCD_W'(1) : r_ccd);
    w_idle_nxt     = 1'b1;
    case (r_state)
      S_IDLE:                                  w_idle_nxt = !w_ref_start && (!w_accept || w_hit);
      S_ACT, S_RCD_WAIT, S_REF, S_RFC_WAIT:    w_idle_nxt = (r_wait == '0);
      S_PRE, S_RP_WAIT, S_PREA, S_RP_ALL_WAIT: w_idle_nxt = 1'b0;
      default:                                 w_idle_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_ccd         <= '0;
      r_refi        <= '0;
      r_open        <= '0;
      for (int i = 0; i < 8; i++) r_row[i] <= '0;
      r_we          <= 1'b0;
      r_bank        <= '0;
      r_req_row     <= '0;
      r_req_col     <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_op    <= OP_NOP;
      bus.cmd_bank  <= '0;
      bus.cmd_addr  <= '0;
      bus.req_ready <= 1'b0;
      ref_pending   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      bus.cmd_valid <= 1'b0;
      bus.cmd_op    <= OP_NOP;
      bus.cmd_bank  <= '0;
      bus.cmd_addr  <= '0;
      r_wait        <= (r_wait != '0) ? r_wait - WAIT_W'(1) : r_wait;
      r_ccd         <= w_ccd_nxt;
      ref_pending   <= w_ref_pend_nxt;
      busy          <= !w_idle_nxt;
      bus.req_ready <= w_idle_nxt && init_done && !w_ref_pend_nxt && (w_ccd_nxt == '0);

      // Refresh interval timer; frozen until the DRAM is initialised.
      if (!init_done || (r_refi == '0)) r_refi <= REFI_W'(T_REFI - 1);
      else                              r_refi <= r_refi - REFI_W'(1);

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we      <= bus.req_we;
            r_bank    <= bus.req_bank;
            r_req_row <= bus.req_row;
            r_req_col <= bus.req_col;
            bus.cmd_valid <= 1'b1;
            bus.cmd_bank  <= bus.req_bank;
            if (w_hit) begin
              bus.cmd_op   <= bus.req_we ? OP_WR : OP_RD;
              bus.cmd_addr <= ROW_W'(bus.req_col);
              r_state      <= S_IDLE;
            end else if (r_open[bus.req_bank]) begin
              bus.cmd_op           <= OP_PRE;
              r_open[bus.req_bank] <= 1'b0;
              r_wait               <= WAIT_W'(T_RP - 1);
              r_state              <= S_PRE;
            end else begin
              bus.cmd_op           <= OP_ACT;
              bus.cmd_addr         <= bus.req_row;
              r_open[bus.req_bank] <= 1'b1;
              r_row[bus.req_bank]  <= bus.req_row;
              r_wait               <= WAIT_W'(T_RCD - 1);
              r_state              <= S_ACT;
            end
          end else if (w_ref_start) begin
            bus.cmd_valid <= 1'b1;
            if (w_any_open) begin
              bus.cmd_op   <= OP_PREA;
              bus.cmd_addr <= PREA_ADDR;
              r_open       <= '0;
              r_wait       <= WAIT_W'(T_RP - 1);
              r_state      <= S_PREA;
            end else begin
              bus.cmd_op <= OP_REF;
              r_wait     <= WAIT_W'(T_RFC - 1);
              r_state    <= S_REF;
            end
          end
        end
        S_ACT, S_RCD_WAIT: begin
          if (r_wait == '0) begin
            bus.cmd_valid <= 1'b1;
            bus.cmd_op    <= r_we ? OP_WR : OP_RD;
            bus.cmd_bank  <= r_bank;
            bus.cmd_addr  <= ROW_W'(r_req_col);
            r_state       <= S_IDLE;
          end else begin
            r_state <= S_RCD_WAIT;
          end
        end
        S_PRE, S_RP_WAIT: begin
          if (r_wait == '0) begin
            bus.cmd_valid  <= 1'b1;
            bus.cmd_op     <= OP_ACT;
            bus.cmd_bank   <= r_bank;
            bus.cmd_addr   <= r_req_row;
            r_open[r_bank] <= 1'b1;
            r_row[r_bank]  <= r_req_row;
            r_wait         <= WAIT_W'(T_RCD - 1);
            r_state        <= S_ACT;
          end else begin
            r_state <= S_RP_WAIT;
          end
        end
        S_PREA, S_RP_ALL_WAIT: begin
          if (r_wait == '0) begin
            bus.cmd_valid <= 1'b1;
            bus.cmd_op    <= OP_REF;
            r_wait        <= WAIT_W'(T_RFC - 1);
            r_state       <= S_REF;
          end else begin
            r_state <= S_RP_ALL_WAIT;
          end
        end
        S_REF, S_RFC_WAIT: begin
          r_state <= (r_wait == '0) ? S_IDLE : S_RFC_WAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// Scoreboard bench for ddr3_cmd_sched: expected commands (op/bank/addr/cycle)
// are queued at request acceptance or refresh detection and popped on cmd_valid.
module tb_ddr3_cmd_sched;
  localparam int unsigned ROW_W  = 15;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned T_RCD  = 3;
  localparam int unsigned T_RP   = 3;
  localparam int unsigned T_RFC  = 20;
  localparam int unsigned T_REFI = 200;
  localparam int unsigned T_CCD  = 4;

  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_PRE  = 3'd4;
  localparam logic [2:0] OP_PREA = 3'd5;
  localparam logic [2:0] OP_REF  = 3'd6;

  logic cpu_clk = 1'b0;
  logic reset   = 1'b1;
  logic init_done = 1'b0;
  logic ref_pending;
  logic busy;

  ddr3_cmd_sched_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  ddr3_cmd_sched #(
    .ROW_W(ROW_W), .COL_W(COL_W), .T_RCD(T_RCD), .T_RP(T_RP),
    .T_RFC(T_RFC), .T_REFI(T_REFI), .T_CCD(T_CCD)
  ) u_dut (
    .cpu_clk     (cpu_clk),
    .reset       (reset),
    .init_done   (init_done),
    .bus         (bus),
    .ref_pending (ref_pending),
    .busy        (busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]       op;
    logic [2:0]       bank;
    logic [ROW_W-1:0] addr;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int last_rw_cyc = -100;
  int p_ref = 0;
  bit               mdl_open [8];
  logic [ROW_W-1:0] mdl_row  [8];

  // Command monitor: every strobe must match the head of the expectation queue.
  exp_t e;
  always @(negedge cpu_clk) begin
    if (cyc > 0) begin
      checks++;
      if (bus.cmd_valid !== (bus.cmd_op != 3'd0)) begin
        failures++;
        $display("FAIL cmd_valid_vs_op: cyc=%0d valid=%b op=%0d", cyc, bus.cmd_valid, bus.cmd_op);
      end
      if (bus.cmd_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_cmd: cyc=%0d op=%0d bank=%0d addr=%0h expected none",
                   cyc, bus.cmd_op, bus.cmd_bank, bus.cmd_addr);
        end else begin
          e = exp_q.pop_front();
          if (bus.cmd_op !== e.op || bus.cmd_bank !== e.bank || bus.cmd_addr !== e.addr || cyc != e.cyc) begin
            failures++;
            $display("FAIL cmd_seq: got op=%0d bank=%0d addr=%0h cyc=%0d expected op=%0d bank=%0d addr=%0h cyc=%0d",
                     bus.cmd_op, bus.cmd_bank, bus.cmd_addr, cyc, e.op, e.bank, e.addr, e.cyc);
          end
          if (bus.cmd_op == OP_RD || bus.cmd_op == OP_WR) last_rw_cyc = cyc;
        end
      end
    end
  end

  task automatic push(input logic [2:0] op, input logic [2:0] bank, input logic [ROW_W-1:0] addr, input int c);
    exp_t x;
    x.op = op; x.bank = bank; x.addr = addr; x.cyc = c;
    exp_q.push_back(x);
  endtask

  // Present a request, wait for acceptance, queue its expected commands; returns at accept+1.
  task automatic do_req(input bit we, input logic [2:0] bank, input logic [ROW_W-1:0] row,
                        input logic [COL_W-1:0] col, input int bound, output int t);
    logic [2:0] rw_op;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_bank  = bank;
    bus.req_row   = row;
    bus.req_col   = col;
    rw_op = we ? OP_WR : OP_RD;
    t = -1;
    for (int i = 0; i < bound; i++) begin
      if (bus.req_ready === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge cpu_clk);
    end
    checks++;
    if (t < 0) begin
      failures++;
      $display("FAIL req_accept_timeout: bank=%0d row=%0h not accepted within %0d cycles", bank, row, bound);
    end else if (mdl_open[bank] && mdl_row[bank] == row) begin
      push(rw_op, bank, ROW_W'(col), t + 1);
    end else if (mdl_open[bank]) begin
      push(OP_PRE, bank, '0, t + 1);
      push(OP_ACT, bank, row, t + 1 + T_RP);
      push(rw_op, bank, ROW_W'(col), t + 1 + T_RP + T_RCD);
    end else begin
      push(OP_ACT, bank, row, t + 1);
      push(rw_op, bank, ROW_W'(col), t + 1 + T_RCD);
    end
    if (t >= 0) begin
      mdl_open[bank] = 1'b1;
      mdl_row[bank]  = row;
    end
    @(negedge cpu_clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge cpu_clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d commands still expected, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      mdl_open[i] = 1'b0;
      mdl_row[i]  = '0;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_bank  = 3'd1;
    bus.req_row   = ROW_W'(5);
    bus.req_col   = COL_W'(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      checks++;
      if ({bus.cmd_valid, bus.cmd_op, bus.cmd_bank, bus.cmd_addr, bus.req_ready, ref_pending, busy} !== '0) begin
        failures++;
        $display("FAIL reset_values: valid=%b op=%0d bank=%0d addr=%0h ready=%b refp=%b busy=%b required all 0",
                 bus.cmd_valid, bus.cmd_op, bus.cmd_bank, bus.cmd_addr, bus.req_ready, ref_pending, busy);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      checks++;
      if (bus.req_ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL no_init_idle: ready=%b busy=%b required 0 0", bus.req_ready, busy);
      end
    end
    bus.req_valid = 1'b0;
    init_done = 1'b1;
    @(negedge cpu_clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_init: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_read_empty();
    int t;
    do_req(1'b0, 3'd2, ROW_W'('h10), COL_W'('h8), 10, t);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (busy !== (k < 4)) begin
        failures++;
        $display("FAIL busy_act_rd: accept+%0d got %b required %b", k, busy, (k < 4));
      end
      if (k < 4) @(negedge cpu_clk);
    end
    wait_drain(10);
  endtask

  task automatic test_write_hit();
    int t;
    int rd_c;
    rd_c = last_rw_cyc;
    do_req(1'b1, 3'd2, ROW_W'('h10), COL_W'('h20), 10, t);
    wait_drain(10);
    checks++;
    if (last_rw_cyc - rd_c != T_CCD) begin
      failures++;
      $display("FAIL ccd_spacing: got %0d cycles required %0d", last_rw_cyc - rd_c, T_CCD);
    end
  endtask

  task automatic test_conflict();
    int t;
    do_req(1'b0, 3'd2, ROW_W'('h11), COL_W'('h4), 10, t);
    wait_drain(15);
  endtask

  task automatic test_refresh();
    int t;
    int bad;
    int ref_c;
    for (int i = 0; i < 400 && ref_pending !== 1'b1; i++) @(negedge cpu_clk);
    checks++;
    if (ref_pending !== 1'b1) begin
      failures++;
      $display("FAIL ref_pending_timeout: got %b required 1", ref_pending);
      return;
    end
    p_ref = cyc;
    ref_c = p_ref + 1 + T_RP;
    push(OP_PREA, 3'd0, ROW_W'(1024), p_ref + 1);
    push(OP_REF, 3'd0, '0, ref_c);
    for (int i = 0; i < 8; i++) mdl_open[i] = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_bank  = 3'd2;
    bus.req_row   = ROW_W'('h11);
    bus.req_col   = COL_W'('h5);
    bad = 0;
    while (cyc < ref_c - 1) begin
      if (bus.req_ready !== 1'b0) bad++;
      @(negedge cpu_clk);
    end
    checks++;
    if (bad != 0 || bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_during_refresh: %0d cycles with ready high, required 0", bad);
    end
    checks++;
    if (ref_pending !== 1'b1) begin
      failures++;
      $display("FAIL ref_pending_before_ref: got %b required 1", ref_pending);
    end
    @(negedge cpu_clk);
    checks++;
    if (ref_pending !== 1'b0) begin
      failures++;
      $display("FAIL ref_pending_at_ref: got %b required 0", ref_pending);
    end
    do_req(1'b0, 3'd2, ROW_W'('h11), COL_W'('h5), 40, t);
    checks++;
    if (t != ref_c + T_RFC) begin
      failures++;
      $display("FAIL ready_after_rfc: accept cyc %0d required %0d", t, ref_c + T_RFC);
    end
    wait_drain(10);
  endtask

  task automatic test_expiry_collision();
    int t;
    while (cyc < p_ref + T_REFI - 1) @(negedge cpu_clk);
    do_req(1'b0, 3'd5, ROW_W'('h7), COL_W'('h3), 1, t);
    checks++;
    if (t != p_ref + T_REFI - 1) begin
      failures++;
      $display("FAIL collide_accept: accept cyc %0d required %0d", t, p_ref + T_REFI - 1);
    end
    checks++;
    if (ref_pending !== 1'b1) begin
      failures++;
      $display("FAIL collide_ref_pending: got %b required 1", ref_pending);
    end
    if (t >= 0) begin
      push(OP_PREA, 3'd0, ROW_W'(1024), t + 2 + T_RCD);
      push(OP_REF, 3'd0, '0, t + 2 + T_RCD + T_RP);
      for (int i = 0; i < 8; i++) mdl_open[i] = 1'b0;
    end
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    int t;
    int bad;
    do_req(1'b0, 3'd3, ROW_W'('h22), COL_W'('h1), 40, t);
    @(negedge cpu_clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rcd_wait: got %b required 1", busy);
    end
    reset = 1'b1;
    init_done = 1'b0;
    @(negedge cpu_clk);
    reset = 1'b0;
    checks++;
    if ({bus.cmd_valid, bus.cmd_op, bus.cmd_bank, bus.cmd_addr, bus.req_ready, ref_pending, busy} !== '0) begin
      failures++;
      $display("FAIL mid_reset_values: valid=%b op=%0d bank=%0d addr=%0h ready=%b refp=%b busy=%b required all 0",
               bus.cmd_valid, bus.cmd_op, bus.cmd_bank, bus.cmd_addr, bus.req_ready, ref_pending, busy);
    end
    checks++;
    if (exp_q.size() != 1) begin
      failures++;
      $display("FAIL mid_reset_queue: %0d pending expectations, required 1", exp_q.size());
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) mdl_open[i] = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge cpu_clk);
      if (bus.cmd_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL quiet_after_reset: %0d active cycles, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_read_empty();
    test_write_hit();
    test_conflict();
    test_refresh();
    test_expiry_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
